// File: rtl/conv_sequencer.sv
// conv_sequencer: initiator-side sequencer for the matrix accelerator.
// The host loads operand beats into an internal FIFO and issues start. The block issues one
// beat at a time to the accelerator, waits for every lane to report done, triggers the
// final add, then holds the captured sum until the host acknowledges it.
//
// Ports:
//   Clk, Rst_n                         clock, asynchronous active-low reset
//   ld_valid/ld_ready                  operand beat handshake (IDLE only)
//   ld_multiplier/ld_multiplicand      flat operand vectors for one beat
//   start, beat_count                  run request and number of beats to run
//   busy, err                          run in progress; sticky error (cleared by a good start)
//   multiplier_out/multiplicand_out    registered operands to the accelerator
//   mStart/mReady                      per-lane multiply start pulse / done
//   finalAdd, cReady, cSum             final-accumulate pulse, sum valid, sum
//   result, result_valid, result_ack   captured sum handshake to the host
module conv_sequencer #(
  parameter int unsigned BIT_LENGTH = 16,
  parameter int unsigned PORT_COUNT = 3,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                             Clk,
  input  logic                             Rst_n,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [PORT_COUNT*BIT_LENGTH-1:0] ld_multiplier,
  input  logic [PORT_COUNT*BIT_LENGTH-1:0] ld_multiplicand,
  input  logic                             start,
  input  logic [$clog2(DEPTH):0]           beat_count,
  output logic                             busy,
  output logic                             err,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplier_out,
  output logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicand_out,
  output logic [PORT_COUNT-1:0]            mStart,
  input  logic [PORT_COUNT-1:0]            mReady,
  output logic                             finalAdd,
  input  logic                             cReady,
  input  logic [2*BIT_LENGTH-1:0]          cSum,
  output logic [2*BIT_LENGTH-1:0]          result,
  output logic                             result_valid,
  input  logic                             result_ack
);

  localparam int unsigned OP_W   = PORT_COUNT * BIT_LENGTH;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT_M = 3'd2;
  localparam logic [2:0] S_FINAL  = 3'd3;
  localparam logic [2:0] S_WAIT_C = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  logic [2:0]            r_state;
  logic [OP_W-1:0]       r_mem_mul [DEPTH];
  logic [OP_W-1:0]       r_mem_mcd [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count, r_beats;
  logic [PORT_COUNT-1:0] r_flags, r_mready_prev, r_mstart;
  logic                  r_cready_prev, r_final, r_err;
  logic [WAIT_W-1:0]     r_wait;
  logic [OP_W-1:0]       r_mul_out, r_mcd_out;
  logic [2*BIT_LENGTH-1:0] r_result;

  logic [2:0]            w_state_nxt;
  logic [PTR_W-1:0]      w_wr_inc, w_rd_inc, w_issue_ptr;
  logic [PORT_COUNT-1:0] w_flags_all;
  logic w_full, w_push, w_pop, w_flush, w_err_set, w_err_clr, w_load_beats, w_capture;
  logic w_m_done, w_c_rise, w_timeout, w_start_ok;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  // A start in the same cycle takes priority over loading.
  assign ld_ready = (r_state == S_IDLE) && !w_full && !start;
  assign w_push   = ld_valid && ld_ready;

  assign w_wr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  // Only rising edges count, so a level left high by the previous beat is ignored.
  assign w_flags_all = r_flags | (mReady & ~r_mready_prev);
  assign w_m_done    = &w_flags_all;
  assign w_c_rise    = cReady && !r_cready_prev;
  assign w_timeout   = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_start_ok  = (beat_count != '0) && (beat_count <= r_count);

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    w_load_beats = 1'b0;
    w_capture    = 1'b0;
    w_issue_ptr  = r_rd_ptr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_start_ok) begin
            w_err_clr    = 1'b1;
            w_load_beats = 1'b1;
            w_state_nxt  = S_ISSUE;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT_M;
      S_WAIT_M: begin
        if (w_m_done) begin
          w_pop       = 1'b1;
          w_issue_ptr = w_rd_inc;
          w_state_nxt = (r_beats == CNT_W'(1)) ? S_FINAL : S_ISSUE;
        end else if (w_timeout) begin
          w_flush     = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FINAL: w_state_nxt = S_WAIT_C;
      S_WAIT_C: begin
        if (w_c_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (w_timeout) begin
          w_flush     = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: if (result_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem_mul[r_wr_ptr] <= ld_multiplier;
      r_mem_mcd[r_wr_ptr] <= ld_multiplicand;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_beats       <= '0;
      r_flags       <= '0;
      r_mready_prev <= '0;
      r_cready_prev <= 1'b0;
      r_wait        <= '0;
      r_err         <= 1'b0;
      r_mul_out     <= '0;
      r_mcd_out     <= '0;
      r_mstart      <= '0;
      r_final       <= 1'b0;
      r_result      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_mready_prev <= mReady;
      r_cready_prev <= cReady;

      // Loads happen only in IDLE and pops/flushes only while waiting, so these never overlap.
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (w_push) begin
        r_wr_ptr <= w_wr_inc;
        r_count  <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_rd_ptr <= w_rd_inc;
        r_count  <= r_count - CNT_W'(1);
      end

      if (w_err_set) r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;

      if (w_load_beats) r_beats <= beat_count;
      else if (w_pop) r_beats <= r_beats - CNT_W'(1);

      if (r_state == S_ISSUE) r_flags <= '0;
      else if (r_state == S_WAIT_M) r_flags <= w_flags_all;

      // Every entry to a wait state passes through ISSUE or FINAL, which restarts the count.
      if (r_state == S_ISSUE || r_state == S_FINAL) r_wait <= '0;
      else if (r_state == S_WAIT_M || r_state == S_WAIT_C) r_wait <= r_wait + WAIT_W'(1);

      // Operands and the start pulse become visible together in the ISSUE cycle.
      if (w_state_nxt == S_ISSUE) begin
        r_mul_out <= r_mem_mul[w_issue_ptr];
        r_mcd_out <= r_mem_mcd[w_issue_ptr];
      end
      r_mstart <= {PORT_COUNT{w_state_nxt == S_ISSUE}};
      r_final  <= (w_state_nxt == S_FINAL);

      if (w_capture) r_result <= cSum;
    end
  end

  assign busy             = (r_state != S_IDLE) && (r_state != S_HOLD);
  assign result_valid     = (r_state == S_HOLD);
  assign err              = r_err;
  assign multiplier_out   = r_mul_out;
  assign multiplicand_out = r_mcd_out;
  assign mStart           = r_mstart;
  assign finalAdd         = r_final;
  assign result           = r_result;

endmodule
